// File: rtl/ws2811_multi.sv
// Multi-string WS2811 driver: CHANNELS parallel serial outputs in lockstep,
// NUM_LEDS LEDs per string, colours fetched per LED through a shared address.
module ws2811_multi #(
    parameter int CHANNELS = 4,
    parameter int NUM_LEDS = 50,
    parameter int T0H      = 50,
    parameter int T1H      = 120,
    parameter int TBIT     = 250,
    parameter int TRESET   = 5000,
    localparam int ADDR_W  = ($clog2(NUM_LEDS) > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  order,
    input  logic [7:0]            brightness,
    input  logic [8*CHANNELS-1:0] red_in,
    input  logic [8*CHANNELS-1:0] green_in,
    input  logic [8*CHANNELS-1:0] blue_in,
    output logic [ADDR_W-1:0]     address,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CHANNELS-1:0]   dout
);

    localparam int CNT_MAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(TBIT - 1);
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(TRESET - 1);
    localparam logic [CNT_W-1:0]  HIGH0      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0]  HIGH1      = CNT_W'(T1H);
    localparam logic [ADDR_W-1:0] LED_LAST   = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, LATCH, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]           cnt;
    logic [4:0]                 bit_idx;
    logic [ADDR_W-1:0]          led_idx;
    logic [CHANNELS-1:0][23:0]  shift;
    logic [CHANNELS-1:0][23:0]  fresh;

    logic bit_end, last_bit, last_led, latch_end;

    assign bit_end   = (cnt == BIT_LAST);
    assign last_bit  = (bit_idx == 5'd23);
    assign last_led  = (led_idx == LED_LAST);
    assign latch_end = (cnt == LATCH_LAST);

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    always_comb begin
        fresh = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (order)
                fresh[c] = {scale(red_in[8*c +: 8], brightness),
                            scale(green_in[8*c +: 8], brightness),
                            scale(blue_in[8*c +: 8], brightness)};
            else
                fresh[c] = {scale(green_in[8*c +: 8], brightness),
                            scale(red_in[8*c +: 8], brightness),
                            scale(blue_in[8*c +: 8], brightness)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  state_next = SEND;
            SEND:  if (bit_end && last_bit && last_led) state_next = LATCH;
            LATCH: if (latch_end) state_next = DONE;
            // busy is already low in DONE, so a held start chains the next frame here
            DONE:  state_next = start ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            led_idx    <= '0;
            shift      <= '0;
            address    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dout       <= '0;
        end else begin
            busy       <= (state_next == LOAD) || (state_next == SEND) || (state_next == LATCH);
            frame_done <= (state_next == DONE);
            case (state)
                LOAD: begin
                    shift   <= fresh;
                    cnt     <= '0;
                    bit_idx <= '0;
                    led_idx <= '0;
                    dout    <= '1;
                end
                SEND: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (last_bit) begin
                            if (last_led) begin
                                dout <= '0;
                            end else begin
                                shift   <= fresh;
                                bit_idx <= '0;
                                led_idx <= led_idx + 1'b1;
                                dout    <= '1;
                            end
                        end else begin
                            for (int unsigned c = 0; c < CHANNELS; c++)
                                shift[c] <= {shift[c][22:0], 1'b0};
                            bit_idx <= bit_idx + 1'b1;
                            dout    <= '1;
                            // Address moves as bit 23 starts, one full bit ahead of the capture
                            if (bit_idx == 5'd22)
                                address <= last_led ? '0 : address + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        for (int unsigned c = 0; c < CHANNELS; c++)
                            dout[c] <= ((cnt + 1'b1) < (shift[c][23] ? HIGH1 : HIGH0));
                    end
                end
                LATCH: begin
                    cnt  <= latch_end ? '0 : cnt + 1'b1;
                    dout <= '0;
                end
                default: begin
                    cnt  <= '0;
                    dout <= '0;
                end
            endcase
        end
    end

endmodule
